// File: rtl/freq_scan_sequencer.sv
// Frequency-counter scan sequencer.
// Walks the DUT index across the input mux. For every design enabled in the
// latched mask it selects the input, waits a settle interval, fires one
// measurement and collects the count, falling back to an all-ones timeout
// result. Each result is offered on a valid/ready beat.
module freq_scan_sequencer #(
    parameter int NDESIGNS       = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int COUNT_WIDTH    = 32,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   start,
    input  logic [NDESIGNS-1:0]    design_mask,
    output logic [DATA_WIDTH-1:0]  select_input,
    output logic                   mux_enable,
    output logic                   meas_start,
    input  logic                   meas_done,
    input  logic [COUNT_WIDTH-1:0] meas_count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [DATA_WIDTH-1:0]  result_index,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   result_timeout,
    output logic                   busy,
    output logic                   scan_done
);

    localparam int IDX_W = (NDESIGNS > 1) ? $clog2(NDESIGNS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NDESIGNS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    // The counter holds (WAIT cycles - 1); the timeout fires on the WAIT
    // cycle where it would step to TIMEOUT_CYCLES-1, so the result appears
    // exactly TIMEOUT_CYCLES clocks after the meas_start cycle.
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEEK    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_TRIGGER = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_REPORT  = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    logic [2:0]          state;
    logic [NDESIGNS-1:0] mask;
    logic [IDX_W-1:0]    index;
    logic [SET_W-1:0]    settle_cnt;
    logic [TO_W-1:0]     to_cnt;

    // Single-cycle strobes and status are pure decodes of the state.
    assign meas_start   = (state == S_TRIGGER);
    assign result_valid = (state == S_REPORT);
    assign scan_done    = (state == S_FINISH);
    assign busy         = (state != S_IDLE);

    // Scan FSM with its index, settle and timeout counters and result hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= S_IDLE;
            mask           <= '0;
            index          <= '0;
            settle_cnt     <= '0;
            to_cnt         <= '0;
            select_input   <= '0;
            mux_enable     <= 1'b0;
            result_index   <= '0;
            result_count   <= '0;
            result_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask  <= design_mask;
                        index <= '0;
                        state <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (mask[index]) begin
                        select_input <= DATA_WIDTH'(index);
                        mux_enable   <= 1'b1;
                        settle_cnt   <= SETTLE_LOAD;
                        state        <= S_SETTLE;
                    end else if (index == LAST_IDX) begin
                        state <= S_FINISH;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_TRIGGER;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                S_TRIGGER: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A done on the final cycle still counts as a real result.
                    if (meas_done) begin
                        result_count   <= meas_count;
                        result_timeout <= 1'b0;
                        result_index   <= DATA_WIDTH'(index);
                        state          <= S_REPORT;
                    end else if (to_cnt == TO_LAST) begin
                        result_count   <= '1;
                        result_timeout <= 1'b1;
                        result_index   <= DATA_WIDTH'(index);
                        state          <= S_REPORT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        mux_enable <= 1'b0;
                        if (index == LAST_IDX) begin
                            state <= S_FINISH;
                        end else begin
                            index <= index + 1'b1;
                            state <= S_SEEK;
                        end
                    end
                end
                S_FINISH: begin
                    mux_enable <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/freq_scan_sequencer.md
Name: freq_scan_sequencer

Overview:
Sequencer for the frequency-counter front end. Walks the design-under-test index across the input multiplexer and drives its select and enable lines. For each enabled design it waits a settle interval, triggers one measurement, and collects the count with a timeout guard. Each result is handed to the host/FIFO side over a valid/ready handshake.

Parameters:
NDESIGNS, 24, number of multiplexer inputs / designs to scan
DATA_WIDTH, 16, width of the mux select bus
COUNT_WIDTH, 32, width of measured frequency count
SETTLE_CYCLES, 16, clocks to wait after a select change before measuring (>=1)
TIMEOUT_CYCLES, 1000000, max clocks to wait for meas_done (>=2)

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a scan (ignored while busy)
design_mask  input  NDESIGNS  bit i=1: design i is scanned; sampled on accepted start
select_input  output  DATA_WIDTH  mux select, index of current design
mux_enable  output  1  drives mux nReset; 1 = mux passes signal
meas_start  output  1  one-cycle pulse to the measurement module
meas_done  input  1  one-cycle pulse: meas_count valid
meas_count  input  COUNT_WIDTH  measured count, valid with meas_done
result_valid  output  1  result beat available
result_ready  input  1  consumer accepts beat when valid&ready
result_index  output  DATA_WIDTH  design index of the result
result_count  output  COUNT_WIDTH  count (all ones on timeout)
result_timeout  output  1  1 = measurement timed out
busy  output  1  1 in any state other than IDLE
scan_done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (synchronous, Reset=1 at an edge): state IDLE. Every output 0: select_input, mux_enable, meas_start, result_valid, result_index, result_count, result_timeout, busy, scan_done. Internal index, settle and timeout counters cleared. Reset mid-scan aborts immediately; any pending result is discarded.
- States: IDLE, SEEK, SETTLE, TRIGGER, WAIT, REPORT, FINISH.
- IDLE: on start=1, latch design_mask, set index=0, go to SEEK. busy=1 from the next cycle.
- SEEK: examines one index per clock.
  - mask[index]=1: select_input<=index, mux_enable<=1, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise index++. If the index was NDESIGNS-1, go to FINISH.
  - All-zero mask: NDESIGNS SEEK cycles, then FINISH. No results are emitted.
- SETTLE: counter decrements each clock. At 0, go to TRIGGER. Total dwell is exactly SETTLE_CYCLES clocks.
- TRIGGER: meas_start=1 for exactly this one cycle. Timeout counter<=0. Go to WAIT.
- WAIT:
  - On meas_done=1: capture meas_count into result_count, result_timeout<=0, result_index<=index, go to REPORT.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1: result_count<=all ones, result_timeout<=1, go to REPORT.
  - meas_done on that same final cycle wins; it is not a timeout.
  - meas_done outside WAIT is ignored.
- REPORT: result_valid=1. result_index, result_count and result_timeout stay stable until accepted. On result_ready=1:
  - result_valid drops the next cycle.
  - mux_enable<=0.
  - If index=NDESIGNS-1, go to FINISH; else index++ and go to SEEK.
  - Backpressure is unbounded; result_ready is ignored when valid=0.
- FINISH: scan_done=1 for one cycle, mux_enable=0, go to IDLE. busy falls the following cycle. A start in FINISH is ignored; a start in IDLE the cycle after is accepted.
- select_input holds its last value between designs and after the scan; only mux_enable gates the mux.
- Indices are zero-extended to DATA_WIDTH. NDESIGNS must be <= 2^DATA_WIDTH.
- Latency per enabled design with no backpressure: 1 (SEEK) + SETTLE_CYCLES + 1 (TRIGGER) + WAIT cycles + 1 (REPORT).

Test Plan:
1. Reset, then mask=24'h000005, start, SETTLE_CYCLES=16, meas_done 10 clocks after each meas_start with counts 1234 and 5678, ready=1 -> two beats (index 0, 1234, timeout=0) and (index 2, 5678, timeout=0); mux_enable high only around each; exactly one meas_start per design; scan_done after the second beat.
2. mask=0, start -> no meas_start, no result_valid; scan_done pulses 25 clocks after start; busy low again the next cycle.
3. mask=bit 23 only, meas_done never asserted, TIMEOUT_CYCLES=50 -> one beat, index 23, count 32'hFFFFFFFF, timeout=1, issued 50 clocks after meas_start.
4. mask=24'hFFFFFF, result_ready held low 100 cycles on the first beat -> valid and data stable throughout; no second meas_start; after ready, 24 beats in index order 0..23.
5. Assert Reset during WAIT of design 3 -> all outputs 0 next cycle; a fresh start rescans from index 0; a stray meas_done in IDLE is ignored.
6. start pulsed while busy, and meas_done coincident with the timeout expiry cycle -> second start ignored; result carries meas_count with timeout=0.
